// File: rtl/apb_loader_pkg.sv
// ---------------------------------------------------------------------------
// apb_loader_pkg
// Shared types and constants for the APB image loader.
//   loader_state_e : top-level job sequencing states
//   START_ADDR     : address of the watermark block's start register
//   FIRST_ADDR     : address that receives the first stream word
//   START_VALUE    : value written to the start register to launch a job
//   APB_WRITE      : PWRITE level; the loader only ever writes
// ---------------------------------------------------------------------------
package apb_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_FETCH        = 3'd1,
        ST_SETUP        = 3'd2,
        ST_ACCESS       = 3'd3,
        ST_START_SETUP  = 3'd4,
        ST_START_ACCESS = 3'd5,
        ST_WAIT_DONE    = 3'd6
    } loader_state_e;

    localparam int unsigned START_ADDR  = 0;
    localparam int unsigned FIRST_ADDR  = 1;
    localparam logic [15:0] START_VALUE = 16'h0001;
    localparam logic        APB_WRITE   = 1'b1;

endpackage

// File: rtl/apb_write_phase.sv
// ---------------------------------------------------------------------------
// apb_write_phase
// Two-cycle APB write sequencer (SETUP then ACCESS). A start_i pulse loads
// address/data and opens a SETUP phase on the next cycle; the following cycle
// is ACCESS. A start_i pulse during ACCESS chains straight into a new SETUP
// so PSEL stays high across back-to-back writes. All outputs are registered.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   start_i      : request a write (honoured when idle or in ACCESS)
//   addr_i       : address for the requested write
//   data_i       : data for the requested write
//   psel_o       : APB PSEL
//   penable_o    : APB PENABLE
//   paddr_o      : APB PADDR (held from SETUP through ACCESS)
//   pwdata_o     : APB PWDATA (held from SETUP through ACCESS)
// ---------------------------------------------------------------------------
module apb_write_phase #(
    parameter int AW = 21,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    output logic          psel_o,
    output logic          penable_o,
    output logic [AW-1:0] paddr_o,
    output logic [DW-1:0] pwdata_o
);

    logic          psel_q,    psel_d;
    logic          penable_q, penable_d;
    logic [AW-1:0] paddr_q,   paddr_d;
    logic [DW-1:0] pwdata_q,  pwdata_d;

    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        if (psel_q && !penable_q) begin
            // SETUP always advances to ACCESS (no PREADY on this bus)
            penable_d = 1'b1;
        end else if (start_i) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = addr_i;
            pwdata_d  = data_i;
        end else if (penable_q) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;

endmodule

// File: rtl/apb_image_loader.sv
// ---------------------------------------------------------------------------
// apb_image_loader
// APB requester that streams a watermarking job into the data bank (one APB
// write per stream word, addresses 0x01 upward), then writes 0x0001 to the
// start register at 0x00 and waits for Image_Done.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   go              : single-cycle job request, ignored while busy
//   in_valid/in_ready/in_data/in_last : word stream handshake
//   Image_Done      : job-complete level from the watermarking block
//   PADDR, PSEL, PENABLE, PWRITE, PWDATA : APB requester outputs
//   busy            : job in progress (go accepted until done)
//   done            : one-cycle pulse when Image_Done is seen after launch
//   err             : sticky address-overflow flag, cleared by next go
// ---------------------------------------------------------------------------
module apb_image_loader
    import apb_loader_pkg::*;
#(
    parameter int Amba_Word       = 16,
    parameter int Amba_Addr_Depth = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic                   in_valid,
    input  logic [Amba_Word-1:0]   in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic                   Image_Done,
    output logic [Amba_Addr_Depth:0] PADDR,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [Amba_Word-1:0]   PWDATA,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int AW = Amba_Addr_Depth + 1;
    localparam int DW = Amba_Word;

    loader_state_e state_q;
    logic [AW-1:0] addr_cnt_q;
    logic          last_q;
    logic          drop_q;     // overflow seen: swallow words until in_last
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic          accept;
    logic          data_write;
    logic          start_write;
    logic          overflow;
    loader_state_e word_state;
    logic          ph_start;
    logic [AW-1:0] ph_addr;
    logic [DW-1:0] ph_data;

    assign in_ready   = (state_q == ST_FETCH) || ((state_q == ST_ACCESS) && !last_q);
    assign accept     = in_ready && in_valid;
    assign data_write = accept && !drop_q;
    // A non-final word landing on the all-ones address is the last one that fits
    assign overflow   = data_write && (&addr_cnt_q) && !in_last;
    // Start write follows either the final data ACCESS or the dropped final word
    assign start_write = ((state_q == ST_ACCESS) && last_q) || (accept && drop_q && in_last);

    always_comb begin
        word_state = ST_SETUP;
        if (drop_q) begin
            word_state = in_last ? ST_START_SETUP : ST_FETCH;
        end
    end

    assign ph_start = data_write || start_write;
    assign ph_addr  = start_write ? AW'(START_ADDR) : addr_cnt_q;
    assign ph_data  = start_write ? DW'(START_VALUE) : in_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_cnt_q <= AW'(FIRST_ADDR);
            last_q     <= 1'b0;
            drop_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_q    <= ST_FETCH;
                        addr_cnt_q <= AW'(FIRST_ADDR);
                        last_q     <= 1'b0;
                        drop_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                    end
                end
                ST_FETCH, ST_ACCESS: begin
                    if ((state_q == ST_ACCESS) && last_q) begin
                        state_q <= ST_START_SETUP;
                    end else if (accept) begin
                        state_q <= word_state;
                        if (data_write) begin
                            last_q     <= in_last;
                            addr_cnt_q <= addr_cnt_q + AW'(1);
                        end
                        if (overflow) begin
                            err_q  <= 1'b1;
                            drop_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_SETUP:        state_q <= ST_ACCESS;
                ST_START_SETUP:  state_q <= ST_START_ACCESS;
                ST_START_ACCESS: state_q <= ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (Image_Done) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    apb_write_phase #(
        .AW(AW),
        .DW(DW)
    ) u_phase (
        .clk      (clk),
        .rst      (rst),
        .start_i  (ph_start),
        .addr_i   (ph_addr),
        .data_i   (ph_data),
        .psel_o   (PSEL),
        .penable_o(PENABLE),
        .paddr_o  (PADDR),
        .pwdata_o (PWDATA)
    );

    assign PWRITE = APB_WRITE;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: doc/apb_image_loader.md
# apb_image_loader

APB requester that loads a watermarking job into the watermark data bank and launches it. It accepts a word stream (parameters, then primary and watermark pixels, in address order) over a valid/ready handshake and issues one APB write per word from address 0x01 upward. It then writes the start register at 0x00 and waits for `Image_Done`. It sits on the CPU side of the APB bus, opposite the watermarking slave.

## Interface
- `Amba_Word`, 16, APB data width.
- `Amba_Addr_Depth`, 20, APB address is `Amba_Addr_Depth+1` bits.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `go`  in  1  single-cycle job request; ignored while `busy`.
- `in_valid`  in  1  stream word valid.
- `in_data`  in  `Amba_Word`  stream word (word k goes to address 0x01+k).
- `in_last`  in  1  marks final stream word.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `Image_Done`  in  1  job-complete level from the watermarking block.
- `PADDR`  out  `Amba_Addr_Depth+1`  APB address.
- `PSEL`  out  1  APB select.
- `PENABLE`  out  1  APB enable.
- `PWRITE`  out  1  APB direction; always 1.
- `PWDATA`  out  `Amba_Word`  APB write data.
- `busy`  out  1  job in progress (`go` accepted until `done`).
- `done`  out  1  one-cycle pulse when `Image_Done` is seen after launch.
- `err`  out  1  sticky address-overflow flag; cleared by next accepted `go`.

## Operation
- States: IDLE, FETCH, SETUP, ACCESS, START_SETUP, START_ACCESS, WAIT_DONE.
- IDLE: `go` -> FETCH. Address counter = 0x01, `busy`=1, `err`=0.
- FETCH: `in_ready`=1 and `PSEL`=0. On `in_valid`, capture `in_data` into the PWDATA register, `in_last` into `last_q`, and the counter into PADDR. Counter += 1. Go to SETUP.
- SETUP: `PSEL`=1, `PENABLE`=0, `PWRITE`=1. Go to ACCESS.
- ACCESS: `PSEL`=1, `PENABLE`=1.
  - If `last_q`, go to START_SETUP.
  - Otherwise `in_ready`=1. If `in_valid`, capture the next word and go to SETUP (back-to-back, `PSEL` stays 1). If not, go to FETCH.
- START_SETUP / START_ACCESS: one write of 0x0001 to address 0x00, same phase rules as SETUP/ACCESS. Then go to WAIT_DONE.
- WAIT_DONE: `PSEL`=0. When `Image_Done`=1, pulse `done`, set `busy`=0, and go to IDLE.
- Overflow: a word is accepted while the counter is all-ones and `in_last`=0.
  - That word is still written at the all-ones address.
  - `err` is set.
  - All further words are accepted and dropped (no APB transfer) until `in_last`.
  - The start write is then issued normally.
- `in_ready` is 0 in IDLE, SETUP, START_*, WAIT_DONE, and in ACCESS when `last_q`=1.
- `go` asserted in any state other than IDLE has no effect.

## Timing
- Reset values: `PADDR`=0, `PSEL`=0, `PENABLE`=0, `PWRITE`=1, `PWDATA`=0, `in_ready`=0, `busy`=0, `done`=0, `err`=0, state IDLE, counter 0x01.
- `go` at cycle 0: FETCH at cycle 1. With `in_valid` at cycle 1: SETUP at 2, ACCESS at 3.
- Sustained throughput is one word per 2 cycles. N words with no stalls plus the start write take 2N+3 cycles from `go` to START_ACCESS.
- APB outputs are registered. `PADDR`/`PWDATA` are stable from SETUP through ACCESS. `PENABLE` is only ever 1 in the cycle after a SETUP.
- No PREADY: every ACCESS completes in one cycle.
- `Image_Done` already high on entry to WAIT_DONE: `done` fires on the next cycle.
- `rst` mid-transfer drops `PSEL`/`PENABLE` immediately (async). Any partial job is abandoned. No start write is issued.

## Structure
- Package `apb_loader_pkg` holds:
  - the state enum;
  - `START_ADDR`=0x00, `FIRST_ADDR`=0x01, `START_VALUE`=16'h0001;
  - `APB_WRITE`=1'b1.
- The word-accept and address-counter logic, the APB phase FSM, and the done detector all live in one module.
- One sub-module is natural: `apb_write_phase`, a two-cycle SETUP/ACCESS sequencer shared by data writes and the start write.

## Test plan
- Reset, then `go` with a 12-word stream always valid -> 12 SETUP/ACCESS pairs to 0x01..0x0C with matching data and `PSEL` continuous. Then the 0x00 <- 0x0001 write, then `PSEL`=0.
- `in_valid` deasserted for 3 cycles after word 2 -> `PSEL`=0 during the gap. Word 3 goes to 0x03. `in_ready` stays 1 during FETCH.
- `Image_Done` raised 20 cycles after the start write -> `done` is a one-cycle pulse the next cycle, `busy` falls with it, and further `go` is accepted.
- `go` pulses while `busy` -> no change to state, address, or `err`.
- Counter preset near the top via `Amba_Addr_Depth`=3 and a 17-word stream -> `err`=1. Only addresses 0x01..0x0F are written, the remaining words are dropped, and the start write still occurs.
- `rst` asserted during an ACCESS -> all outputs are at reset values the same cycle. A subsequent `go` restarts from 0x01.
